bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock. It sits directly upstream of the 4-digit multiplexed 7-segment sweep driver and feeds its disp0..disp3 inputs. Converted digits are held stable between conversions. Optional leading-zero blanking drives code 4'hF, which the sweep driver renders as a blank digit.

---
 rtl/bin2bcd_seq.sv | 143 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding a 4-digit display.
// Digits, overflow flag and optional leading-zero blanking are registered on the final iteration.
module bin2bcd_seq #(
   parameter int NBITS  = 14,
   parameter int MAXVAL = 9999
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NBITS-1:0] bin,
   input  logic             blankLZ,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [3:0]       disp0,
   output logic [3:0]       disp1,
   output logic [3:0]       disp2,
   output logic [3:0]       disp3
);

   localparam int ND   = (NBITS <= 14) ? 4 : (NBITS + 2) / 3;
   localparam int BCDW = 4 * ND;
   localparam int CW   = $clog2(NBITS + 1);
   localparam logic [31:0] MAXV = 32'(MAXVAL);

   typedef enum logic {IDLE, CONV} state_t;

   state_t            state_q, state_d;
   logic [NBITS-1:0]  bin_sh_q, bin_sh_d;
   logic [BCDW-1:0]   bcd_q, bcd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              blank_q, blank_d;
   logic              ovf_pend_q, ovf_pend_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;
   logic [15:0]       disp_q, disp_d;

   logic [BCDW-1:0]   bcd_nxt;
   logic [NBITS-1:0]  bin_nxt;
   logic [15:0]       fin;
   logic [3:0]        nib, adj;
   logic              carry;
   logic              gt;

   assign gt      = 32'(bin) > MAXV;
   assign bin_nxt = {bin_sh_q[NBITS-2:0], 1'b0};

   // Add-3 per nibble, then shift; each adjusted nibble's MSB carries into the next one up.
   always_comb begin
      bcd_nxt = '0;
      nib     = '0;
      adj     = '0;
      carry   = bin_sh_q[NBITS-1];
      for (int i = 0; i < ND; i++) begin
         nib = bcd_q[4*i +: 4];
         adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
         bcd_nxt[4*i +: 4] = {adj[2:0], carry};
         carry = adj[3];
      end
   end

   always_comb begin
      fin = bcd_nxt[15:0];
      if (ovf_pend_q) begin
         fin = 16'hFFFF;
      end else if (blank_q && fin[15:12] == 4'h0) begin
         fin[15:12] = 4'hF;
         if (fin[11:8] == 4'h0) begin
            fin[11:8] = 4'hF;
            if (fin[7:4] == 4'h0) fin[7:4] = 4'hF;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      bin_sh_d   = bin_sh_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      blank_d    = blank_q;
      ovf_pend_d = ovf_pend_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      disp_d     = disp_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_sh_d   = bin;
               blank_d    = blankLZ;
               ovf_pend_d = gt;
               bcd_d      = '0;
               cnt_d      = '0;
               state_d    = CONV;
            end
         end
         CONV: begin
            bin_sh_d = bin_nxt;
            bcd_d    = bcd_nxt;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(NBITS - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               ovf_d   = ovf_pend_q;
               disp_d  = fin;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         bin_sh_q   <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         blank_q    <= 1'b0;
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         disp_q     <= '0;
      end else begin
         state_q    <= state_d;
         bin_sh_q   <= bin_sh_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         blank_q    <= blank_d;
         ovf_pend_q <= ovf_pend_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         disp_q     <= disp_d;
      end
   end

   assign busy     = (state_q == CONV);
   assign done     = done_q;
   assign overflow = ovf_q;
   assign disp0    = disp_q[3:0];
   assign disp1    = disp_q[7:4];
   assign disp2    = disp_q[11:8];
   assign disp3    = disp_q[15:12];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq: latency, digits, blanking, overflow, back-to-back and reset abort.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [13:0] bin = '0;
   logic        blankLZ = 1'b0;
   logic        busy, done, overflow;
   logic [3:0]  disp0, disp1, disp2, disp3;
   int          checks = 0;
   int          failures = 0;

   bin2bcd_seq #(.NBITS(14), .MAXVAL(9999)) dut (
      .clk(clk), .rst(rst), .start(start), .bin(bin), .blankLZ(blankLZ),
      .busy(busy), .done(done), .overflow(overflow),
      .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] digits();
      return {disp3, disp2, disp1, disp0};
   endfunction

   // Starts one conversion and returns the edge count from the accepting edge to done (-1 on timeout).
   task automatic run_conv(input logic [13:0] v, input logic blz, output int lat, output logic b0);
      @(negedge clk);
      bin = v; blankLZ = blz; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b0 = busy;
      start = 1'b0; bin = '0; blankLZ = ~blz;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, overflow} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got %b exp 000", {busy, done, overflow});
      end
      checks++;
      if (digits() !== 16'h0000) begin
         failures++; $display("FAIL reset_digits got %h exp 0000", digits());
      end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_basic;
      int lat; logic b0;
      run_conv(14'd1234, 1'b0, lat, b0);
      checks++;
      if (b0 !== 1'b1) begin failures++; $display("FAIL basic_busy_start got %b exp 1", b0); end
      checks++;
      if (lat !== 14) begin failures++; $display("FAIL basic_latency got %0d exp 14", lat); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done got %b exp 0", busy); end
      checks++;
      if (digits() !== 16'h1234) begin failures++; $display("FAIL basic_digits got %h exp 1234", digits()); end
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf got %b exp 0", overflow); end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got %b exp 0", done); end
      checks++;
      if (digits() !== 16'h1234) begin failures++; $display("FAIL basic_hold got %h exp 1234", digits()); end
   endtask

   task automatic test_blanking;
      int lat; logic b0;
      logic [13:0] vals [3] = '{14'd0, 14'd105, 14'd9999};
      logic [15:0] exps [3] = '{16'hFFF0, 16'hF105, 16'h9999};
      for (int k = 0; k < 3; k++) begin
         run_conv(vals[k], 1'b1, lat, b0);
         checks++;
         if (lat !== 14) begin failures++; $display("FAIL blank_latency_%0d got %0d exp 14", vals[k], lat); end
         checks++;
         if (digits() !== exps[k]) begin
            failures++; $display("FAIL blank_digits_%0d got %h exp %h", vals[k], digits(), exps[k]);
         end
         checks++;
         if (overflow !== 1'b0) begin failures++; $display("FAIL blank_ovf_%0d got %b exp 0", vals[k], overflow); end
      end
   endtask

   task automatic test_overflow;
      int lat; logic b0;
      logic [13:0] vals [2] = '{14'd10000, 14'd16383};
      for (int k = 0; k < 2; k++) begin
         run_conv(vals[k], 1'b1, lat, b0);
         checks++;
         if (digits() !== 16'hFFFF) begin
            failures++; $display("FAIL ovf_digits_%0d got %h exp FFFF", vals[k], digits());
         end
         checks++;
         if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag_%0d got %b exp 1", vals[k], overflow); end
      end
      run_conv(14'd42, 1'b0, lat, b0);
      checks++;
      if (digits() !== 16'h0042) begin failures++; $display("FAIL ovf_clear_digits got %h exp 0042", digits()); end
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear_flag got %b exp 0", overflow); end
   endtask

   task automatic test_start_ignored;
      int ndone = 0; int first = -1; logic [15:0] got = '0;
      @(negedge clk);
      bin = 14'd2468; blankLZ = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); start = 1'b1; bin = 14'd5678;
      @(posedge clk);
      @(negedge clk); start = 1'b0; bin = '0;
      // Edges E6 onward; the single done should follow E14.
      for (int i = 6; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (first < 0) begin first = i; got = digits(); end
         end
      end
      checks++;
      if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
      checks++;
      if (first !== 14) begin failures++; $display("FAIL ignore_latency got %0d exp 14", first); end
      checks++;
      if (got !== 16'h2468) begin failures++; $display("FAIL ignore_digits got %h exp 2468", got); end
   endtask

   task automatic test_back_to_back;
      int edges [2] = '{-1, -1};
      logic [15:0] got [2] = '{16'h0, 16'h0};
      int n = 0;
      @(negedge clk);
      bin = 14'd7; blankLZ = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); bin = 14'd8;
      for (int i = 1; i <= 60 && n < 2; i++) begin
         @(posedge clk); #1;
         if (done) begin edges[n] = i; got[n] = digits(); n++; end
      end
      @(negedge clk); start = 1'b0; bin = '0;
      checks++;
      if (edges[0] !== 14) begin failures++; $display("FAIL b2b_first_edge got %0d exp 14", edges[0]); end
      checks++;
      if (edges[1] !== 29) begin failures++; $display("FAIL b2b_second_edge got %0d exp 29", edges[1]); end
      checks++;
      if (got[0] !== 16'h0007) begin failures++; $display("FAIL b2b_first_digits got %h exp 0007", got[0]); end
      checks++;
      if (got[1] !== 16'h0008) begin failures++; $display("FAIL b2b_second_digits got %h exp 0008", got[1]); end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_reset_mid;
      int lat; logic b0; int saw = 0;
      @(negedge clk);
      bin = 14'd4321; blankLZ = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy, done, overflow} !== 3'b000) begin
         failures++; $display("FAIL rstmid_flags got %b exp 000", {busy, done, overflow});
      end
      checks++;
      if (digits() !== 16'h0000) begin failures++; $display("FAIL rstmid_digits got %h exp 0000", digits()); end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) saw++;
         if (i == 3) rst = 1'b1;
      end
      checks++;
      if (saw !== 0) begin failures++; $display("FAIL rstmid_no_done got %0d exp 0", saw); end
      run_conv(14'd4321, 1'b0, lat, b0);
      checks++;
      if (lat !== 14) begin failures++; $display("FAIL rstmid_latency got %0d exp 14", lat); end
      checks++;
      if (digits() !== 16'h4321) begin failures++; $display("FAIL rstmid_digits_after got %h exp 4321", digits()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blanking();
      test_overflow();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
